aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
Sequencer for the single-round AES-128 key-expansion unit (key_single_round). It accepts a cipher key and launches the round unit ten times, supplying the correct rcon and feeding each result back as the next input. It stores all 11 round keys (index 0 = cipher key) in a register file read by the cipher datapath. It sits between the host/config interface and the shared round-key unit.

Parameters:
NUM_ROUNDS, 10, number of expansion rounds; round-key file depth is NUM_ROUNDS+1
TIMEOUT_CYC, 64, watchdog limit in cycles per round (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  start request; accepted only when ready_o=1
key_i  in  128  cipher key, sampled on an accepted start
abort_i  in  1  abandon the current expansion and return to IDLE
ready_o  out  1  controller can accept start_i
busy_o  out  1  expansion in progress
done_o  out  1  all round keys valid; sticky until the next accepted start
err_o  out  1  watchdog timeout (optional feature only, otherwise tied 0)
rd_idx_i  in  4  round-key file read index, 0..NUM_ROUNDS
rd_key_o  out  128  combinational read of entry rd_idx_i; 0 if index > NUM_ROUNDS
rk_rst_o  out  1  active-high launch/reset pulse to the round unit
rk_clk_en_o  out  1  clock enable to the round unit; equals busy_o
rk_rcon_o  out  8  rcon for the current round
rk_iv_o  out  32  equals rk_key_o[31:0]
rk_key_o  out  128  round-unit input key
rk_key_i  in  128  round-unit output key
rk_valid_i  in  1  round-unit key valid

Behaviour:
- Reset values: IDLE, ready_o=1, busy_o=0, done_o=0, err_o=0, rk_rst_o=1, rk_rcon_o=8'h01, rk_key_o=0, round=1, every file entry=0.
- States are IDLE, LAUNCH, WAIT, DONE, and ERR (ERR only with the optional feature).
- IDLE/DONE: ready_o=1 and rk_rst_o=1.
  - start_i: file[0]<=key_i, rk_key_o<=key_i, round<=1, rcon<=8'h01, done_o<=0, then go to LAUNCH.
- LAUNCH: exactly one cycle with rk_rst_o=1 and busy_o=1, then go to WAIT.
- WAIT: rk_rst_o=0. rk_key_o and rk_rcon_o are held stable. On rk_valid_i:
  - file[round]<=rk_key_i and rk_key_o<=rk_key_i.
  - If round==NUM_ROUNDS: go to DONE and set done_o=1 the next cycle.
  - Otherwise: round<=round+1, rcon<={rcon[6:0],1'b0}^(rcon[7]?8'h1b:8'h00), then go to LAUNCH.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- rk_valid_i is ignored in every state except WAIT. Only one capture per round.
- Round latency equals 1 cycle plus the round unit's latency. There is no fixed internal bound.
- abort_i has priority over rk_valid_i in the same cycle. It moves any state to IDLE with done_o=0 and rk_rst_o=1. File contents are retained but not valid.
- start_i while busy is ignored. start_i together with abort_i in IDLE/DONE: abort wins and start is dropped.
- A read of an index while it is being written returns the old value. The new value appears the next cycle.
- Asynchronous reset mid-expansion: all state returns to reset values immediately. The round unit is held in reset via rk_rst_o=1.

Optional Feature:
KEY_SCHED_TIMEOUT_EN
- Defined:
  - A per-round counter clears in LAUNCH and increments in WAIT.
  - If it reaches TIMEOUT_CYC without rk_valid_i, go to ERR: err_o=1, busy_o=0, rk_rst_o=1, ready_o=1.
  - ERR behaves like IDLE for start_i. An accepted start clears err_o.
  - abort_i in ERR clears err_o and moves to IDLE.
- Undefined: no counter and no ERR state; err_o is tied 0.

Test Plan:
- FIPS-197 key: start with key_i=2b7e151628aed2a6abf7158809cf4f3c, using the real round unit.
  - file[1]=a0fafe1788542cb123a339392a6c7605.
  - file[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done_o=1.
  - rk_rcon_o trace across rounds: 01..36 as listed in Behaviour.
- Handshake check: exactly 10 one-cycle rk_rst_o pulses are seen, and rk_key_o stays stable throughout each WAIT. start_i pulsed mid-run is ignored and round keys are unchanged.
- Abort at round 5 with rk_valid_i in the same cycle: the controller enters IDLE, file[5] is not written, done_o=0. A new start then completes correctly.
- Back-to-back: a start accepted in DONE with key 000102030405060708090a0b0c0d0e0f gives file[10]=13111d7fe3944a17f307a78b4d2b30c5. done_o drops the cycle after the start.
- Reset mid-run: rst_ni low in WAIT immediately gives ready_o=1, busy_o=0, done_o=0, and every rd_key_o=0.
- With KEY_SCHED_TIMEOUT_EN and a round unit that never asserts rk_valid_i: err_o rises exactly TIMEOUT_CYC=64 cycles after LAUNCH. A following start clears err_o.

Source files
------------

// File: rtl/aes_key_sched_ctrl_if.sv
// Bus between the key-schedule sequencer (master) and the shared single-round
// AES-128 key-expansion unit (slave).
interface aes_key_sched_ctrl_if;
    logic         rk_rst_o;
    logic         rk_clk_en_o;
    logic [7:0]   rk_rcon_o;
    logic [31:0]  rk_iv_o;
    logic [127:0] rk_key_o;
    logic [127:0] rk_key_i;
    logic         rk_valid_i;

    modport master (
        output rk_rst_o, rk_clk_en_o, rk_rcon_o, rk_iv_o, rk_key_o,
        input  rk_key_i, rk_valid_i
    );

    modport slave (
        input  rk_rst_o, rk_clk_en_o, rk_rcon_o, rk_iv_o, rk_key_o,
        output rk_key_i, rk_valid_i
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: drives the round unit ten times and keeps all round keys.
// Optional per-round watchdog with ERR state enabled by defining KEY_SCHED_TIMEOUT_EN.
module aes_key_sched_ctrl #(
    parameter int NUM_ROUNDS = 10
`ifdef KEY_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [127:0]         key_i,
    input  logic                 abort_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    input  logic [3:0]           rd_idx_i,
    output logic [127:0]         rd_key_o,
    aes_key_sched_ctrl_if.master rk
);
    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

`ifdef KEY_SCHED_TIMEOUT_EN
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE, S_ERR} state_e;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic             err_q, err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
`else
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_e;
`endif

    state_e         state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [127:0]   key_q, key_d;
    logic           done_q, done_d;
    logic [127:0]   file_q [NUM_ROUNDS+1];
    logic [127:0]   file_d [NUM_ROUNDS+1];

    function automatic logic [7:0] rcon_next(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            round_q <= 4'd1;
            rcon_q  <= 8'h01;
            key_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) file_q[i] <= '0;
`ifdef KEY_SCHED_TIMEOUT_EN
            err_q   <= 1'b0;
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            key_q   <= key_d;
            done_q  <= done_d;
            file_q  <= file_d;
`ifdef KEY_SCHED_TIMEOUT_EN
            err_q   <= err_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

`ifdef KEY_SCHED_TIMEOUT_EN
    assign ready_o = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
    assign err_o   = err_q;
`else
    assign ready_o = (state_q == S_IDLE) || (state_q == S_DONE);
    assign err_o   = 1'b0;
`endif
    assign busy_o         = (state_q == S_LAUNCH) || (state_q == S_WAIT);
    assign done_o         = done_q;
    assign rk.rk_rst_o    = (state_q != S_WAIT);
    assign rk.rk_clk_en_o = busy_o;
    assign rk.rk_rcon_o   = rcon_q;
    assign rk.rk_key_o    = key_q;
    assign rk.rk_iv_o     = key_q[31:0];

    always_comb begin
        rd_key_o = '0;
        if (rd_idx_i <= LAST_IDX) rd_key_o = file_q[rd_idx_i];
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        key_d   = key_q;
        done_d  = done_q;
        file_d  = file_q;
`ifdef KEY_SCHED_TIMEOUT_EN
        err_d   = err_q;
        tmo_d   = tmo_q;
`endif
        // abort outranks both a new start and a same-cycle round result
        if (abort_i) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
`ifdef KEY_SCHED_TIMEOUT_EN
            err_d   = 1'b0;
`endif
        end else if (ready_o && start_i) begin
            file_d[0] = key_i;
            key_d     = key_i;
            round_d   = 4'd1;
            rcon_d    = 8'h01;
            done_d    = 1'b0;
            state_d   = S_LAUNCH;
`ifdef KEY_SCHED_TIMEOUT_EN
            err_d     = 1'b0;
`endif
        end else begin
            case (state_q)
                S_LAUNCH: begin
                    state_d = S_WAIT;
`ifdef KEY_SCHED_TIMEOUT_EN
                    tmo_d   = TMO_W'(1);  // launch cycle counts toward the round budget
`endif
                end
                S_WAIT: begin
                    if (rk.rk_valid_i) begin
                        file_d[round_q] = rk.rk_key_i;
                        key_d           = rk.rk_key_i;
                        if (round_q == LAST_IDX) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            round_d = round_q + 4'd1;
                            rcon_d  = rcon_next(rcon_q);
                            state_d = S_LAUNCH;
                        end
                    end
`ifdef KEY_SCHED_TIMEOUT_EN
                    else begin
                        tmo_d = tmo_q + TMO_W'(1);
                        if (tmo_d == TMO_W'(TIMEOUT_CYC)) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: behavioural AES-128 round unit plus key-expansion reference model.
module tb_aes_key_sched_ctrl;
    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         start  = 1'b0;
    logic         abort  = 1'b0;
    logic [127:0] key    = '0;
    logic [3:0]   rd_idx = '0;
    logic         ready, busy, done, err;
    logic [127:0] rd_key;

    aes_key_sched_ctrl_if rk ();

    aes_key_sched_ctrl dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .key_i    (key),
        .abort_i  (abort),
        .ready_o  (ready),
        .busy_o   (busy),
        .done_o   (done),
        .err_o    (err),
        .rd_idx_i (rd_idx),
        .rd_key_o (rd_key),
        .rk       (rk)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_tab [256];
    logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] ref_keys [11];
    logic [127:0] exp_file [16];

    typedef struct {
        logic [127:0] key;
        int           lat;
        bit           mid;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs [6];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    int  lat = 1;
    bit  never_valid = 1'b0;
    int  ru_cnt = 0;

    int  n_launch = 0, n_bad_pulse = 0, n_unstable = 0, n_iv_bad = 0, n_en_bad = 0, n_err_bad = 0;
    logic [7:0] rcon_seen [$];
    bit  prev_launch = 1'b0, prev_wait = 1'b0;
    logic [127:0] prev_key = '0;
    logic [7:0]   prev_rcon = '0;

    int  base_l, base_r, r_ab, tmo_n;
    bit  found;
    logic [127:0] k_rand, old_val;

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = '0; aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = '0;
        for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] next_round_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, r, t;
        {w0, w1, w2, w3} = k;
        r  = {w3[23:0], w3[31:24]};
        t  = {sbox_tab[r[31:24]], sbox_tab[r[23:16]], sbox_tab[r[15:8]], sbox_tab[r[7:0]]}
             ^ {rc, 24'h0};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    task automatic expand(input logic [127:0] k);
        ref_keys[0] = k;
        for (int r = 1; r <= 10; r++) ref_keys[r] = next_round_key(ref_keys[r-1], rcon_tab[r-1]);
    endtask

    task automatic set_full();
        for (int i = 0; i <= 10; i++) exp_file[i] = ref_keys[i];
    endtask

    // ---------------- behavioural round unit ----------------
    initial begin
        rk.rk_valid_i = 1'b0;
        rk.rk_key_i   = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rk.rk_rst_o || !rk.rk_clk_en_o) begin
                ru_cnt = 0;
                rk.rk_valid_i = 1'b0;
            end else begin
                ru_cnt++;
                if (!never_valid && ru_cnt >= lat) begin
                    rk.rk_valid_i = 1'b1;
                    rk.rk_key_i   = next_round_key(rk.rk_key_o, rk.rk_rcon_o);
                end
            end
        end
    end

    // ---------------- handshake monitor ----------------
    always @(negedge clk) begin
        if (rk.rk_clk_en_o && rk.rk_rst_o) begin
            n_launch++;
            rcon_seen.push_back(rk.rk_rcon_o);
            if (prev_launch) n_bad_pulse++;
        end
        if (rk.rk_clk_en_o && !rk.rk_rst_o && prev_wait &&
            (rk.rk_key_o !== prev_key || rk.rk_rcon_o !== prev_rcon)) n_unstable++;
        if (rk.rk_iv_o !== rk.rk_key_o[31:0]) n_iv_bad++;
        if (rk.rk_clk_en_o !== busy) n_en_bad++;
`ifndef KEY_SCHED_TIMEOUT_EN
        if (err !== 1'b0) n_err_bad++;
`endif
        prev_launch = rk.rk_clk_en_o && rk.rk_rst_o;
        prev_wait   = rk.rk_clk_en_o && !rk.rk_rst_o;
        prev_key    = rk.rk_key_o;
        prev_rcon   = rk.rk_rcon_o;
    end

    // ---------------- check helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check_file(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rd_idx = 4'(i);
            #1;
            chk($sformatf("%s file[%0d]", tag, i), rd_key, exp_file[i]);
        end
    endtask

    task automatic do_start(input logic [127:0] k);
        @(negedge clk);
        start = 1'b1;
        key   = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input bit mid, input logic [127:0] k);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (mid && c == 3) begin
                start = 1'b1;
                key   = ~k;
            end
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk1({nm, " reached done"}, ok, 1'b1);
    endtask

    task automatic abort_at(input int r);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (rk.rk_valid_i && rk.rk_clk_en_o && !rk.rk_rst_o && rk.rk_rcon_o == rcon_tab[r-1]) begin
                abort = 1'b1;
                ok    = 1'b1;
                break;
            end
        end
        chk1("abort round reached", ok, 1'b1);
        @(negedge clk);
        abort = 1'b0;
        chk1("abort busy", busy, 1'b0);
        chk1("abort ready", ready, 1'b1);
        chk1("abort done", done, 1'b0);
        chk1("abort rk_rst", rk.rk_rst_o, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "time limit");
    end

    initial begin
        for (int x = 0; x < 256; x++) sbox_tab[x] = sbox_calc(8'(x));
        for (int i = 0; i < 16; i++) exp_file[i] = '0;

        vecs[0] = '{FIPS_KEY, 1, 1'b0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[1] = '{FIPS_KEY, 3, 1'b1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[2] = '{SEQ_KEY,  2, 1'b0, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[3] = '{SEQ_KEY,  4, 1'b1, 4'd0,  SEQ_KEY};
        vecs[4] = '{FIPS_KEY, 1, 1'b0, 4'd11, 128'h0};
        vecs[5] = '{FIPS_KEY, 2, 1'b0, 4'd15, 128'h0};

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk1("rst ready", ready, 1'b1);
        chk1("rst busy", busy, 1'b0);
        chk1("rst done", done, 1'b0);
        chk1("rst err", err, 1'b0);
        chk1("rst rk_rst", rk.rk_rst_o, 1'b1);
        chk("rst rcon", {120'h0, rk.rk_rcon_o}, 128'h01);
        chk("rst rk_key", rk.rk_key_o, 128'h0);
        check_file("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven full expansions (consecutive entries start from DONE)
        for (int v = 0; v < 6; v++) begin
            lat    = vecs[v].lat;
            base_l = n_launch;
            base_r = rcon_seen.size();
            do_start(vecs[v].key);
            wait_done($sformatf("vec%0d", v), vecs[v].mid, vecs[v].key);
            expand(vecs[v].key);
            set_full();
            chk($sformatf("vec%0d launches", v), 128'(n_launch - base_l), 128'd10);
            for (int j = 0; j < 10; j++)
                chk($sformatf("vec%0d rcon%0d", v, j), {120'h0, rcon_seen[base_r + j]}, {120'h0, rcon_tab[j]});
            @(negedge clk);
            rd_idx = vecs[v].idx;
            #1;
            chk($sformatf("vec%0d table key", v), rd_key, vecs[v].exp);
            chk1($sformatf("vec%0d done sticky", v), done, 1'b1);
            check_file($sformatf("vec%0d", v));
        end

        // back-to-back start from DONE: done drops one cycle after the start
        lat = 1;
        expand(SEQ_KEY);
        do_start(SEQ_KEY);
        chk1("b2b done drop", done, 1'b0);
        chk1("b2b busy", busy, 1'b1);
        wait_done("b2b", 1'b0, SEQ_KEY);
        set_full();
        @(negedge clk);
        rd_idx = 4'd10;
        #1;
        chk("b2b file10", rd_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // read of an entry in its write cycle returns the old value
        old_val = exp_file[1];
        expand(FIPS_KEY);
        do_start(FIPS_KEY);
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (rk.rk_valid_i && !rk.rk_rst_o && rk.rk_rcon_o == 8'h01) begin
                found = 1'b1;
                break;
            end
        end
        chk1("rdw valid seen", found, 1'b1);
        rd_idx = 4'd1;
        #1;
        chk("rdw old value", rd_key, old_val);
        @(negedge clk);
        #1;
        chk("rdw new value", rd_key, ref_keys[1]);
        wait_done("rdw", 1'b0, FIPS_KEY);
        set_full();

        // abort at round 5 together with rk_valid_i
        lat = 2;
        expand(SEQ_KEY);
        do_start(SEQ_KEY);
        abort_at(5);
        exp_file[0] = SEQ_KEY;
        for (int j = 1; j < 5; j++) exp_file[j] = ref_keys[j];
        check_file("abort5");

        // start together with abort in IDLE is dropped
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        key   = FIPS_KEY;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk1("start+abort busy", busy, 1'b0);
        chk1("start+abort ready", ready, 1'b1);

        // fresh start after abort completes
        do_start(SEQ_KEY);
        wait_done("post-abort", 1'b0, SEQ_KEY);
        set_full();
        check_file("post-abort");

        // randomized runs against the reference model
        for (int it = 0; it < 20; it++) begin
            k_rand = {$urandom, $urandom, $urandom, $urandom};
            r_ab   = 0;
            if ($urandom_range(0, 2) == 0) r_ab = int'($urandom_range(1, 10));
            lat = int'($urandom_range(1, 5));
            expand(k_rand);
            do_start(k_rand);
            if (r_ab == 0) begin
                wait_done("rand", $urandom_range(0, 1) == 1, k_rand);
                set_full();
            end else begin
                abort_at(r_ab);
                exp_file[0] = k_rand;
                for (int j = 1; j < r_ab; j++) exp_file[j] = ref_keys[j];
            end
            check_file($sformatf("rand%0d", it));
        end

        // asynchronous reset in WAIT
        lat = 3;
        do_start(FIPS_KEY);
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (rk.rk_clk_en_o && !rk.rk_rst_o && rk.rk_rcon_o == 8'h08) begin
                found = 1'b1;
                break;
            end
        end
        chk1("midrst wait seen", found, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("midrst ready", ready, 1'b1);
        chk1("midrst busy", busy, 1'b0);
        chk1("midrst done", done, 1'b0);
        chk1("midrst rk_rst", rk.rk_rst_o, 1'b1);
        chk("midrst rcon", {120'h0, rk.rk_rcon_o}, 128'h01);
        for (int i = 0; i < 16; i++) exp_file[i] = '0;
        check_file("midrst");
        @(negedge clk);
        rst_n = 1'b1;

`ifdef KEY_SCHED_TIMEOUT_EN
        // watchdog: no rk_valid_i ever
        never_valid = 1'b1;
        do_start(FIPS_KEY);
        chk1("tmo in launch", rk.rk_rst_o & busy, 1'b1);
        tmo_n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            tmo_n++;
            if (err) break;
        end
        chk("tmo cycles", 128'(tmo_n), 128'd64);
        chk1("tmo busy", busy, 1'b0);
        chk1("tmo ready", ready, 1'b1);
        chk1("tmo rk_rst", rk.rk_rst_o, 1'b1);
        never_valid = 1'b0;
        lat = 1;
        expand(SEQ_KEY);
        do_start(SEQ_KEY);
        chk1("tmo err cleared", err, 1'b0);
        wait_done("tmo recover", 1'b0, SEQ_KEY);
        set_full();
        check_file("tmo recover");
`endif

        chk("no double launch", 128'(n_bad_pulse), 128'd0);
        chk("key/rcon stable in wait", 128'(n_unstable), 128'd0);
        chk("iv follows key", 128'(n_iv_bad), 128'd0);
        chk("clk_en equals busy", 128'(n_en_bad), 128'd0);
        chk("err tied low", 128'(n_err_bad), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
